id_stage_ctrl: RTL
==================

Name: id_stage_ctrl

Overview:
Decode-stage controller for the 5-stage RV32I pipeline. It classifies the IF/ID instruction, drives ImmSel to the immediate generator, and captures the returned immediate plus the control bundle into the ID/EX pipeline register. It also sequences load-use bubbles, external memory stalls and EX-stage redirect flushes through a small FSM, and generates the IF and PC stall controls.

Parameters:
XLEN, 32, datapath width for pc and immediate.

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
ifid_valid  in  1  IF/ID holds a real instruction
ifid_inst  in  32  instruction word
ifid_pc  in  XLEN  instruction PC
imm_sel  out  ImmSel_t  combinational select to the immediate generator (decode of ifid_inst)
imm_in  in  XLEN  immediate returned by the generator, same cycle
ex_memread  in  1  instruction in EX is a load
ex_rd  in  5  destination register of the EX instruction
ex_redirect  in  1  EX resolved a taken branch or jump
mem_stall  in  1  data memory not ready; freeze the pipeline
stall_f  out  1  hold PC and IF/ID
idex_valid  out  1  ID/EX valid
idex_pc  out  XLEN  registered PC
idex_imm  out  XLEN  registered immediate
idex_rs1, idex_rs2, idex_rd  out  5 each  register indices
idex_ctrl  out  IdCtrl_t  {reg_write, mem_read, mem_write, branch, jump, jalr, alu_src_imm, result_sel[1:0]}
idex_illegal  out  1  unrecognised opcode captured

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high. On reset, every idex_* output is 0, stall_f is 0, and the FSM enters RUN.
- Opcode decode (combinational; drives imm_sel):
  - 0010011, 0000011, 1100111 -> Imm_I
  - 0100011 -> Imm_S
  - 1100011 -> Imm_B
  - 0110111, 0010111 -> Imm_U
  - 1101111 -> Imm_J
  - 0110011 -> default select, immediate 0
  - anything else -> illegal
- rs1 is used by every class except U and J. rs2 is used by OP, STORE and BRANCH only.
- Load-use hazard: ifid_valid & ex_memread & ex_rd != 0, and (ex_rd == rs1 & uses_rs1, or ex_rd == rs2 & uses_rs2).
- FSM states: RUN and BUBBLE. Priority each cycle is ex_redirect, then mem_stall, then hazard.
  - ex_redirect: idex_valid <= 0, stall_f = 0, state -> RUN. A hazard in the same cycle is ignored.
  - mem_stall (no redirect): all ID/EX registers hold, stall_f = 1, state holds.
  - RUN with hazard: idex_valid <= 0 and idex_ctrl <= 0 (bubble), stall_f = 1, state -> BUBBLE.
  - BUBBLE: hazard evaluation is suppressed for that cycle, so at most one bubble is inserted per load. Capture normally, stall_f = 0, state -> RUN.
  - Otherwise: capture decode results, idex_valid <= ifid_valid & ~illegal, idex_illegal <= ifid_valid & illegal.
- Latency: one cycle from IF/ID to ID/EX.
- stall_f is combinational from the current state and inputs.
- Reset asserted mid-stall or mid-bubble wins unconditionally.
- An invalid IF/ID captures idex_valid = 0, with ctrl and illegal forced to 0.

Decomposition:
- rv32_pkg gains:
  - opcode localparams
  - IdCtrl_t packed struct
  - enum IdState_t {RUN, BUBBLE}
  - ImmSel_t, already present
- One natural sub-module, id_decode: purely combinational, mapping the opcode to imm_sel, ctrl, uses_rs1/uses_rs2 and illegal.
- The top level holds the FSM and the ID/EX registers.

Test Plan:
1. Sequence addi x1,x0,5 then sw x1,8(x2).
   - imm_sel = Imm_I then Imm_S.
   - idex_imm = 5 then 8, one cycle later.
   - ctrl.alu_src_imm = 1 for both.
2. lw x3,0(x4) in EX (ex_memread = 1, ex_rd = 3), add x5,x3,x6 in ID.
   - stall_f = 1 for exactly one cycle.
   - idex_valid = 0 that cycle.
   - add captured next cycle with idex_rs1 = 3.
3. Load with ex_rd = 0 and consumer reading x0: no stall, no bubble.
4. ex_redirect = 1 in the same cycle as a load-use hazard and mem_stall = 1: idex_valid = 0, stall_f = 0, state RUN.
5. mem_stall held for 3 cycles with valid jal (imm 0x800) in ID: all idex_* hold, stall_f = 1 throughout; capture with idex_imm = 0x00000800 after release.
6. Opcode 0x7F illegal: idex_illegal = 1, idex_valid = 0. rst asserted during BUBBLE: next cycle all outputs 0, state RUN.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: opcodes, decode selects and the ID/EX control bundle.
// Consumed by the decode-stage controller and its opcode decoder.
package rv32_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // result_sel encodings for the writeback mux
  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;

  typedef enum logic [2:0] {
    Imm_None,
    Imm_I,
    Imm_S,
    Imm_B,
    Imm_U,
    Imm_J
  } ImmSel_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       alu_src_imm;
    logic [1:0] result_sel;
  } IdCtrl_t;

  typedef enum logic {
    RUN,
    BUBBLE
  } IdState_t;

endpackage

// File: rtl/id_decode.sv
// Combinational opcode classifier: immediate select, control bundle,
// register-use flags and illegal-opcode detection.
module id_decode
  import rv32_pkg::*;
(
  input  logic [6:0] opcode,
  output ImmSel_t    imm_sel,
  output IdCtrl_t    ctrl,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output logic       illegal
);

  always_comb begin
    imm_sel  = Imm_None;
    ctrl     = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    illegal  = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        ctrl.reg_write = 1'b1;
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
      end
      OPC_OP_IMM: begin
        imm_sel          = Imm_I;
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        uses_rs1         = 1'b1;
      end
      OPC_LOAD: begin
        imm_sel          = Imm_I;
        ctrl.reg_write   = 1'b1;
        ctrl.mem_read    = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.result_sel  = RES_MEM;
        uses_rs1         = 1'b1;
      end
      OPC_JALR: begin
        imm_sel          = Imm_I;
        ctrl.reg_write   = 1'b1;
        ctrl.jump        = 1'b1;
        ctrl.jalr        = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.result_sel  = RES_PC4;
        uses_rs1         = 1'b1;
      end
      OPC_STORE: begin
        imm_sel          = Imm_S;
        ctrl.mem_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        uses_rs1         = 1'b1;
        uses_rs2         = 1'b1;
      end
      OPC_BRANCH: begin
        imm_sel     = Imm_B;
        ctrl.branch = 1'b1;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm_sel          = Imm_U;
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
      end
      OPC_JAL: begin
        imm_sel         = Imm_J;
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_sel = RES_PC4;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_stage_ctrl.sv
// Decode-stage controller: ID/EX register capture plus a RUN/BUBBLE FSM that
// orders redirect flushes over memory stalls over load-use bubbles.
module id_stage_ctrl
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ifid_valid,
  input  logic [31:0]     ifid_inst,
  input  logic [XLEN-1:0] ifid_pc,
  output ImmSel_t         imm_sel,
  input  logic [XLEN-1:0] imm_in,
  input  logic            ex_memread,
  input  logic [4:0]      ex_rd,
  input  logic            ex_redirect,
  input  logic            mem_stall,
  output logic            stall_f,
  output logic            idex_valid,
  output logic [XLEN-1:0] idex_pc,
  output logic [XLEN-1:0] idex_imm,
  output logic [4:0]      idex_rs1,
  output logic [4:0]      idex_rs2,
  output logic [4:0]      idex_rd,
  output IdCtrl_t         idex_ctrl,
  output logic            idex_illegal,
  output IdState_t        state_dbg
);

  typedef enum logic [1:0] {
    ACT_CAPTURE,
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_FLUSH
  } id_act_t;

  IdState_t state_q, state_d;
  id_act_t  act;
  IdCtrl_t  dec_ctrl;
  logic     uses_rs1, uses_rs2, illegal, hazard;
  logic [4:0] rs1, rs2, rd;

  assign rs1 = ifid_inst[19:15];
  assign rs2 = ifid_inst[24:20];
  assign rd  = ifid_inst[11:7];

  id_decode u_decode (
    .opcode   (ifid_inst[6:0]),
    .imm_sel  (imm_sel),
    .ctrl     (dec_ctrl),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2),
    .illegal  (illegal)
  );

  assign hazard = ifid_valid & ex_memread & (ex_rd != 5'd0) &
                  (((ex_rd == rs1) & uses_rs1) | ((ex_rd == rs2) & uses_rs2));

  // stall_f holds PC and IF/ID; it is high only for mem_stall or a fresh bubble.
  always_comb begin
    state_d = state_q;
    act     = ACT_CAPTURE;
    stall_f = 1'b0;
    if (rst) begin
      state_d = RUN;
    end else if (ex_redirect) begin
      act     = ACT_FLUSH;
      state_d = RUN;
    end else if (mem_stall) begin
      act     = ACT_HOLD;
      stall_f = 1'b1;
    end else if ((state_q == RUN) && hazard) begin
      act     = ACT_BUBBLE;
      stall_f = 1'b1;
      state_d = BUBBLE;
    end else begin
      act     = ACT_CAPTURE;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      idex_valid   <= 1'b0;
      idex_pc      <= '0;
      idex_imm     <= '0;
      idex_rs1     <= '0;
      idex_rs2     <= '0;
      idex_rd      <= '0;
      idex_ctrl    <= '0;
      idex_illegal <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (act)
        ACT_CAPTURE: begin
          idex_valid   <= ifid_valid & ~illegal;
          idex_illegal <= ifid_valid & illegal;
          idex_ctrl    <= ifid_valid ? dec_ctrl : '0;
          idex_pc      <= ifid_pc;
          // OP and illegal encodings carry no immediate
          idex_imm     <= (imm_sel == Imm_None) ? '0 : imm_in;
          idex_rs1     <= rs1;
          idex_rs2     <= rs2;
          idex_rd      <= rd;
        end
        ACT_BUBBLE, ACT_FLUSH: begin
          idex_valid   <= 1'b0;
          idex_ctrl    <= '0;
          idex_illegal <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign state_dbg = state_q;

endmodule
